adder11_stream: RTL and testbench

Streaming wrapper that turns the combinational 11-bit ripple adder into a flow-controlled pipeline stage.
- Upstream: accepts operand pairs on a valid/ready handshake and registers them.
- Core: drives the existing adder11 from the registered operands.
- Downstream: buffers the 12-bit sums in a small FIFO for a valid/ready consumer.
- Also keeps a saturating count of results with carry-out (sum[11]) set.

---
 rtl/adder11_stream_pkg.sv | 14 +
 rtl/adder11.sv | 21 ++
 rtl/adder11_stream.sv | 91 +++++++++
 tb/tb_adder11_stream.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder11_stream_pkg.sv
// Shared widths and helpers for the streaming 11-bit adder stage.
package adder11_stream_pkg;

   localparam int OP_W  = 11;
   localparam int SUM_W = 12;

   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/adder11.sv
// Combinational 11-bit ripple-carry adder; sum[11] is the carry-out.
module adder11
   import adder11_stream_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic [SUM_W-1:0] sum
);

   always_comb begin
      logic c;
      c   = 1'b0;
      sum = '0;
      for (int i = 0; i < OP_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      sum[OP_W] = c;
   end

endmodule

// File: rtl/adder11_stream.sv
// Flow-controlled wrapper: registered operands -> adder11 -> result FIFO,
// with a saturating count of results that carried out.
module adder11_stream
   import adder11_stream_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OP_W-1:0]         in_a,
   input  logic [OP_W-1:0]         in_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SUM_W-1:0]        out_sum,
   output logic [clog2_f(DEPTH):0] level,
   output logic [CNT_W-1:0]        carry_cnt
);

   localparam int PTR_W = clog2_f(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

   logic                 vld_p1;
   logic [OP_W-1:0]      op_a_p1;
   logic [OP_W-1:0]      op_b_p1;
   logic [SUM_W-1:0]     sum_p1;
   logic [SUM_W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 accept;
   logic                 push;
   logic                 pop;

   // A push into a full FIFO is allowed only when the head leaves in the same cycle.
   assign pop       = out_valid && out_ready;
   assign push      = vld_p1 && ((level != FULL_LVL) || pop);
   assign in_ready  = !vld_p1 || push;
   assign accept    = in_valid && in_ready;

   // ---- stage 1: operand registers feeding the adder core ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         op_a_p1 <= '0;
         op_b_p1 <= '0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         op_a_p1 <= in_a;
         op_b_p1 <= in_b;
      end else if (push) begin
         vld_p1  <= 1'b0;
      end
   end

   adder11 u_adder11 (
      .a   (op_a_p1),
      .b   (op_b_p1),
      .sum (sum_p1)
   );

   // ---- stage 2: result FIFO ----
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sum_p1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         carry_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level + LVL_W'(push) - LVL_W'(pop);
         if (push && sum_p1[SUM_W-1]) carry_cnt <= sat_inc(carry_cnt);
      end
   end

   // Gating on out_valid keeps out_sum at zero while empty without resetting the array.
   assign out_valid = (level != '0);
   assign out_sum   = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_adder11_stream.sv
// Self-checking bench for adder11_stream: table vectors, directed corner cases, random traffic.
module tb_adder11_stream;
   import adder11_stream_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_a;
   logic [10:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_sum;
   logic [2:0]  level;
   logic [7:0]  carry_cnt;

   logic        s_in_ready;
   logic        s_out_valid;
   logic [11:0] s_out_sum;
   logic [2:0]  s_level;
   logic [1:0]  s_carry_cnt;

   always #5 clk = ~clk;

   adder11_stream #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .level(level), .carry_cnt(carry_cnt)
   );

   adder11_stream #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_sum(s_out_sum), .level(s_level), .carry_cnt(s_carry_cnt)
   );

   typedef struct {
      logic [10:0] a;
      logic [10:0] b;
      logic [11:0] sum;
   } vec_t;

   logic [11:0] exp_q[$];
   int          carries;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          last_acc;
   bit          last_pop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Samples just before the rising edge, updates the reference queue, then waits for the next falling edge.
   task automatic tick();
      logic [11:0] e;
      #1;
      last_acc = in_valid && in_ready;
      last_pop = out_valid && out_ready;
      chk("in_ready", 32'(in_ready), ((exp_q.size() < DEPTH + 1) || out_ready) ? 1 : 0);
      if (last_pop) begin
         chk("pending_at_pop", (exp_q.size() != 0) ? 1 : 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_sum", 32'(out_sum), 32'(e));
         end
      end
      if (last_acc) begin
         e = {1'b0, in_a} + {1'b0, in_b};
         exp_q.push_back(e);
         if (e[11]) carries++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      carries = 0;
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
      chk("drained", exp_q.size(), 0);
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("carry_cnt", 32'(carry_cnt), (carries > 255) ? 255 : carries);
      chk("carry_cnt_sat", 32'(s_carry_cnt), (carries > 3) ? 3 : carries);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[6];
      int   nacc;
      int   npop;
      int   ncarry;

      tbl[0] = '{11'h000, 11'h000, 12'h000};
      tbl[1] = '{11'h7FF, 11'h7FF, 12'hFFE};
      tbl[2] = '{11'h400, 11'h3FF, 12'h7FF};
      tbl[3] = '{11'h7FF, 11'h001, 12'h800};
      tbl[4] = '{11'h155, 11'h2AA, 12'h3FF};
      tbl[5] = '{11'h001, 11'h7FF, 12'h800};

      // reset state
      do_reset();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_out_sum", 32'(out_sum), 0);
      chk("rst_carry_cnt", 32'(carry_cnt), 0);
      chk("rst_in_ready", 32'(in_ready), 1);

      // single pair latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a = 11'h7FF;
      in_b = 11'h001;
      tick();
      in_valid = 1'b0;
      chk("single_not_yet_valid", 32'(out_valid), 0);
      tick();
      chk("single_valid", 32'(out_valid), 1);
      chk("single_sum", 32'(out_sum), 'h800);
      tick();
      chk("single_carry_cnt", 32'(carry_cnt), 1);
      drain();

      // table vectors streamed back to back
      do_reset();
      out_ready = 1'b1;
      ncarry = 0;
      for (int c = 0; c < 8; c++) begin
         if (c >= 2) begin
            chk("tbl_valid", 32'(out_valid), 1);
            chk("tbl_sum", 32'(out_sum), 32'(tbl[c-2].sum));
         end
         in_valid = (c < 6);
         if (c < 6) begin
            in_a = tbl[c].a;
            in_b = tbl[c].b;
            if (tbl[c].sum[11]) ncarry++;
         end
         tick();
         if (c < 6) chk("tbl_accept", 32'(last_acc), 1);
      end
      drain();
      chk("tbl_carry_cnt", 32'(carry_cnt), ncarry);

      // backpressure: exactly DEPTH+1 accepts
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      nacc = 0;
      for (int i = 0; i < 10; i++) begin
         in_a = 11'($urandom);
         in_b = 11'($urandom);
         tick();
         if (last_acc) nacc++;
      end
      chk("bp_accepts", nacc, DEPTH + 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_level", 32'(level), DEPTH);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp_ready_same_cycle", 32'(in_ready), 1);
      npop = 0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         tick();
         if (last_pop) npop++;
      end
      chk("bp_pops", npop, DEPTH + 1);
      drain();

      // full with simultaneous push, pop and accept
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_a = 11'($urandom);
         in_b = 11'($urandom);
         tick();
      end
      chk("full_level", 32'(level), DEPTH);
      out_ready = 1'b1;
      in_a = 11'h123;
      in_b = 11'h456;
      #1;
      chk("full_in_ready", 32'(in_ready), 1);
      tick();
      chk("full_accept", 32'(last_acc), 1);
      chk("full_pop", 32'(last_pop), 1);
      chk("full_level_held", 32'(level), DEPTH);
      drain();

      // counter saturation (CNT_W=2 instance)
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a = 11'h7FF;
      in_b = 11'h7FF;
      for (int i = 0; i < 6; i++) tick();
      drain();
      chk("sat_held", 32'(s_carry_cnt), 3);
      chk("sat_wide_cnt", 32'(carry_cnt), 6);

      // reset in the middle of a stream
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a = 11'h7FF;
      in_b = 11'h7FF;
      for (int i = 0; i < 4; i++) tick();
      in_valid = 1'b0;
      chk("mid_level", 32'(level), 3);
      chk("mid_carry_cnt", 32'(carry_cnt), 3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_carry_cnt", 32'(carry_cnt), 0);
      chk("mid_rst_out_sum", 32'(out_sum), 0);
      exp_q.delete();
      carries = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a = 11'h0AB;
      in_b = 11'h101;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5 && !out_valid; i++) tick();
      chk("post_rst_valid", 32'(out_valid), 1);
      chk("post_rst_first", 32'(out_sum), 'h1AC);
      drain();

      // random traffic against the queue model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0:       begin in_a = 11'h7FF; in_b = 11'($urandom); end
            1:       begin in_a = 11'h000; in_b = 11'($urandom); end
            default: begin in_a = 11'($urandom); in_b = 11'($urandom); end
         endcase
         tick();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
